// File: rtl/dca_matrix_step_sequencer.sv
// dca_matrix_step_sequencer: issues matrix steps to the MAC array once load/store LSUs are ready, tracks store credits.
// Optional DCA_STEP_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module dca_matrix_step_sequencer #(
   parameter int MATRIX_SIZE_PARA = 8,
   parameter int NUM_LD_LSU       = 2,
   parameter int STORE_DEPTH      = 4,
   localparam int NUM_ROW   = MATRIX_SIZE_PARA,
   localparam int NUM_COL   = MATRIX_SIZE_PARA,
   localparam int BW_OPCODE = NUM_LD_LSU + 3,
   localparam int BW_INST   = NUM_ROW + NUM_COL + 1 + BW_OPCODE,
   localparam int BW_CRD    = $clog2(STORE_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  enable_i,
   output logic                  busy_o,
   input  logic                  inst_valid_i,
   input  logic [BW_INST-1:0]    inst_i,
   output logic                  inst_ready_o,
   input  logic [NUM_LD_LSU-1:0] ld_ready_i,
   output logic [NUM_LD_LSU-1:0] ld_req_o,
   input  logic                  st_ready_i,
   output logic                  st_push_o,
   input  logic                  st_done_i,
   input  logic                  acc_ready_i,
   output logic                  cal_valid_o,
   output logic [BW_INST-1:0]    cal_inst_o,
   input  logic                  cal_done_i,
   output logic                  last_done_o
`ifdef DCA_STEP_SEQ_PERF_EN
   ,
   output logic [31:0]           perf_busy_cycles_o,
   output logic [31:0]           perf_stall_cycles_o
`endif
);
   typedef enum logic [1:0] {IDLE, CAL, DRAIN} state_t;
   state_t state_q, state_d;
   logic [BW_CRD-1:0] credit_q, credit_d;
   logic op_no_cal, op_st, op_acc, op_last;
   logic [NUM_LD_LSU-1:0] op_ld;
   logic is_idle, st_ok, acc_ok, issue, bypass, cal_fin, drain_fin, st_dec;
   // opcode layout: {LOAD_ACC, STORE, LD[NUM_LD_LSU-1:0], NO_CAL}
   assign op_no_cal = inst_i[0];
   assign op_ld     = inst_i[NUM_LD_LSU:1];
   assign op_st     = inst_i[NUM_LD_LSU+1];
   assign op_acc    = inst_i[NUM_LD_LSU+2];
   assign op_last   = inst_i[BW_OPCODE];
   assign is_idle   = state_q == IDLE;
   assign st_ok     = ~op_st | ((credit_q < BW_CRD'(STORE_DEPTH)) & st_ready_i);
   assign acc_ok    = ~op_acc | acc_ready_i;
   assign issue     = is_idle & inst_valid_i & ~op_no_cal & (&(ld_ready_i | ~op_ld)) & st_ok & acc_ok & enable_i;
   assign bypass    = is_idle & inst_valid_i & op_no_cal & acc_ok & enable_i;
   assign cal_fin   = (state_q == CAL) & cal_done_i & enable_i;
   // the final st_done of a drain may land in the same cycle as the exit decision
   assign drain_fin = (state_q == DRAIN) & enable_i & ((credit_q == '0) | ((credit_q == BW_CRD'(1)) & st_done_i));
   assign st_dec    = st_done_i & (credit_q != '0);
   assign busy_o       = ~is_idle;
   assign cal_valid_o  = issue;
   assign ld_req_o     = issue ? op_ld : '0;
   assign inst_ready_o = bypass | cal_fin;
   assign st_push_o    = cal_fin & op_st;
   assign last_done_o  = drain_fin;
   assign cal_inst_o   = inst_i;
   always_comb begin
      state_d  = issue ? CAL : cal_fin ? (op_last ? DRAIN : IDLE) : drain_fin ? IDLE : state_q;
      credit_d = credit_q + BW_CRD'(st_push_o) - BW_CRD'(st_dec);
   end
   always_ff @(posedge clk) begin
      if (rst | clear_i) begin
         state_q  <= IDLE;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
      end
   end
`ifdef SEQ_ASSERT
   a_st_done_underflow: assert property (@(posedge clk) disable iff (rst || clear_i) !(st_done_i && credit_q == '0));
`endif
`ifdef DCA_STEP_SEQ_PERF_EN
   logic [31:0] perf_busy_q, perf_stall_q;
   logic stall;
   assign stall = is_idle & inst_valid_i & ~issue & ~bypass;
   always_ff @(posedge clk) begin
      if (rst | clear_i) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_busy_q  <= perf_busy_q + {31'b0, busy_o & (perf_busy_q != '1)};
         perf_stall_q <= perf_stall_q + {31'b0, stall & (perf_stall_q != '1)};
      end
   end
   assign perf_busy_cycles_o  = perf_busy_q;
   assign perf_stall_cycles_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_dca_matrix_step_sequencer.sv
// tb_dca_matrix_step_sequencer: per-cycle vector table plus directed multi-cycle sequences.
module tb_dca_matrix_step_sequencer;
   localparam int BW_INST = 22;
   logic clk = 1'b0;
   logic rst, clear_i, enable_i, inst_valid_i, st_ready_i, st_done_i, acc_ready_i, cal_done_i;
   logic [BW_INST-1:0] inst_i;
   logic [1:0] ld_ready_i, ld_req_o;
   logic busy_o, inst_ready_o, st_push_o, cal_valid_o, last_done_o;
   logic [BW_INST-1:0] cal_inst_o;
`ifdef DCA_STEP_SEQ_PERF_EN
   logic [31:0] perf_busy_cycles_o, perf_stall_cycles_o;
`endif
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   dca_matrix_step_sequencer #(.MATRIX_SIZE_PARA(8), .NUM_LD_LSU(2), .STORE_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .clear_i(clear_i), .enable_i(enable_i), .busy_o(busy_o),
      .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_ready_o(inst_ready_o),
      .ld_ready_i(ld_ready_i), .ld_req_o(ld_req_o), .st_ready_i(st_ready_i), .st_push_o(st_push_o),
      .st_done_i(st_done_i), .acc_ready_i(acc_ready_i), .cal_valid_o(cal_valid_o),
      .cal_inst_o(cal_inst_o), .cal_done_i(cal_done_i), .last_done_o(last_done_o)
`ifdef DCA_STEP_SEQ_PERF_EN
      , .perf_busy_cycles_o(perf_busy_cycles_o), .perf_stall_cycles_o(perf_stall_cycles_o)
`endif
   );
   typedef struct {
      string tag;
      logic r, c, e, iv;
      logic [1:0] ld;
      logic st, acc, nc, last;
      logic [1:0] ldr;
      logic str, sd, ar, cd;
      logic busy, ir;
      logic [1:0] ldq;
      logic push, cv, lst;
      logic [2:0] crd;
   } vec_t;
   vec_t tbl[$];
   function automatic logic [BW_INST-1:0] mk(logic [1:0] ld, logic st, logic acc, logic nc, logic last);
      return {8'hA5, 8'h3C, last, acc, st, ld, nc};
   endfunction
   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", n, a, e);
      end
   endtask
   task automatic set(logic iv, logic [1:0] ld, logic st, logic acc, logic nc, logic last,
                      logic [1:0] ldr, logic str, logic sd, logic ar, logic cd);
      inst_valid_i = iv; inst_i = mk(ld, st, acc, nc, last); ld_ready_i = ldr;
      st_ready_i = str; st_done_i = sd; acc_ready_i = ar; cal_done_i = cd;
      #1;
   endtask
   task automatic nx();
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1; set(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); nx(); rst = 1'b0;
   endtask
   initial begin
      rst = 1'b1; clear_i = 1'b0; enable_i = 1'b1;
      tbl.push_back('{"rst_idle",   0,0,1,0,2'b00,0,0,0,0,2'b00,0,0,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"t1_issue",   0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b11,0,1,0,3'd0});
      tbl.push_back('{"t1_cal1",    0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 1,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"t1_cal2",    0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 1,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"t1_done",    0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,1, 1,1,2'b00,1,0,0,3'd0});
      tbl.push_back('{"t1_idle",    0,0,1,0,2'b11,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd1});
      for (int k = 1; k <= 3; k++) begin
         tbl.push_back('{"t2_issue", 0,0,1,1,2'b01,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b01,0,1,0,3'(k)});
         tbl.push_back('{"t2_done",  0,0,1,1,2'b01,1,0,0,0,2'b11,1,0,0,1, 1,1,2'b00,1,0,0,3'(k)});
      end
      tbl.push_back('{"t2_full",    0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd4});
      tbl.push_back('{"t2_full2",   0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd4});
      tbl.push_back('{"t2_stdone",  0,0,1,1,2'b11,1,0,0,0,2'b11,1,1,0,0, 0,0,2'b00,0,0,0,3'd4});
      tbl.push_back('{"t2_issue5",  0,0,1,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b11,0,1,0,3'd3});
      tbl.push_back('{"t5_push_dn", 0,0,1,1,2'b11,1,0,0,0,2'b11,1,1,0,1, 1,1,2'b00,1,0,0,3'd3});
      tbl.push_back('{"t5_crd_eq",  0,0,1,0,2'b11,1,0,0,0,2'b11,1,1,0,0, 0,0,2'b00,0,0,0,3'd3});
      tbl.push_back('{"drain_2",    0,0,1,0,2'b00,0,0,0,0,2'b11,1,1,0,0, 0,0,2'b00,0,0,0,3'd2});
      tbl.push_back('{"drain_1",    0,0,1,0,2'b00,0,0,0,0,2'b11,1,1,0,0, 0,0,2'b00,0,0,0,3'd1});
      tbl.push_back('{"sd_at_0",    0,0,1,0,2'b00,0,0,0,0,2'b11,1,1,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"crd_hold0",  0,0,1,0,2'b00,0,0,0,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"byp_acc",    0,0,1,1,2'b00,0,1,1,0,2'b11,1,0,1,0, 0,1,2'b00,0,0,0,3'd0});
      tbl.push_back('{"byp_wait",   0,0,1,1,2'b00,0,1,1,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"byp_nop",    0,0,1,1,2'b00,0,0,1,0,2'b11,1,0,0,0, 0,1,2'b00,0,0,0,3'd0});
      tbl.push_back('{"acc_stall",  0,0,1,1,2'b00,0,1,0,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"acc_issue",  0,0,1,1,2'b00,0,1,0,0,2'b11,1,0,1,0, 0,0,2'b00,0,1,0,3'd0});
      tbl.push_back('{"acc_done",   0,0,1,1,2'b00,0,1,0,0,2'b11,1,0,1,1, 1,1,2'b00,0,0,0,3'd0});
      tbl.push_back('{"en_off",     0,0,0,1,2'b11,1,0,0,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"en_off_byp", 0,0,0,1,2'b00,0,0,1,0,2'b11,1,0,0,0, 0,0,2'b00,0,0,0,3'd0});
      tbl.push_back('{"cd_idle",    0,0,1,0,2'b00,0,0,0,0,2'b11,1,0,0,1, 0,0,2'b00,0,0,0,3'd0});
      do_reset();
      foreach (tbl[i]) begin
         rst = tbl[i].r; clear_i = tbl[i].c; enable_i = tbl[i].e;
         set(tbl[i].iv, tbl[i].ld, tbl[i].st, tbl[i].acc, tbl[i].nc, tbl[i].last,
             tbl[i].ldr, tbl[i].str, tbl[i].sd, tbl[i].ar, tbl[i].cd);
         chk({tbl[i].tag, "_busy"}, 32'(busy_o), 32'(tbl[i].busy));
         chk({tbl[i].tag, "_inst_ready"}, 32'(inst_ready_o), 32'(tbl[i].ir));
         chk({tbl[i].tag, "_ld_req"}, 32'(ld_req_o), 32'(tbl[i].ldq));
         chk({tbl[i].tag, "_st_push"}, 32'(st_push_o), 32'(tbl[i].push));
         chk({tbl[i].tag, "_cal_valid"}, 32'(cal_valid_o), 32'(tbl[i].cv));
         chk({tbl[i].tag, "_last_done"}, 32'(last_done_o), 32'(tbl[i].lst));
         chk({tbl[i].tag, "_credit"}, 32'(dut.credit_q), 32'(tbl[i].crd));
         chk({tbl[i].tag, "_cal_inst"}, 32'(cal_inst_o), 32'(mk(tbl[i].ld, tbl[i].st, tbl[i].acc, tbl[i].nc, tbl[i].last)));
         nx();
      end
      enable_i = 1'b1;
      // partial load readiness must block issue indefinitely
      for (int k = 0; k < 10; k++) begin
         set(1, 2'b11, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
         chk("t3_stall_cv", 32'(cal_valid_o), 0);
         chk("t3_stall_ldreq", 32'(ld_req_o), 0);
         nx();
      end
      set(1, 2'b11, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t3_issue_cv", 32'(cal_valid_o), 1);
      chk("t3_issue_ldreq", 32'(ld_req_o), 32'h3);
      nx(); set(1, 2'b11, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      chk("t3_done", 32'(inst_ready_o), 1);
      nx();
      for (int k = 0; k < 2; k++) begin
         set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0); nx();
         set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 1); nx();
      end
      set(1, 2'b00, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0);
      chk("t4_issue", 32'(cal_valid_o), 1);
      nx(); set(1, 2'b00, 0, 0, 0, 1, 2'b11, 1, 0, 0, 1);
      chk("t4_cal_done_ir", 32'(inst_ready_o), 1);
      chk("t4_credit_t", 32'(dut.credit_q), 2);
      nx(); set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t4_t1_busy", 32'(busy_o), 1);
      chk("t4_t1_last", 32'(last_done_o), 0);
      nx(); set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0);
      chk("t4_t2_last", 32'(last_done_o), 0);
      nx(); set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t4_t3_credit", 32'(dut.credit_q), 1);
      chk("t4_t3_last", 32'(last_done_o), 0);
      nx(); set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t4_t4_last", 32'(last_done_o), 0);
      chk("t4_t4_busy", 32'(busy_o), 1);
      nx(); set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0);
      chk("t4_t5_last", 32'(last_done_o), 1);
      nx(); set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t4_t6_busy", 32'(busy_o), 0);
      chk("t4_t6_last", 32'(last_done_o), 0);
      chk("t4_t6_credit", 32'(dut.credit_q), 0);
      set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0); nx();
      set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 1); nx();
      set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t6_issue", 32'(cal_valid_o), 1);
      nx(); rst = 1'b1; set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("t6_rst_cal_busy", 32'(busy_o), 1);
      chk("t6_rst_no_ir", 32'(inst_ready_o), 0);
      nx(); rst = 1'b0; set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      chk("t6_after_busy", 32'(busy_o), 0);
      chk("t6_after_credit", 32'(dut.credit_q), 0);
      chk("t6_after_ir", 32'(inst_ready_o), 0);
      nx(); set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0); nx();
      set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 1); nx();
      set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0); nx();
      clear_i = 1'b1; set(1, 2'b00, 1, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("clr_cal_busy", 32'(busy_o), 1);
      chk("clr_credit_pre", 32'(dut.credit_q), 1);
      nx(); clear_i = 1'b0; set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("clr_after_busy", 32'(busy_o), 0);
      chk("clr_after_credit", 32'(dut.credit_q), 0);
`ifdef DCA_STEP_SEQ_PERF_EN
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set(1, 2'b11, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0); nx();
      end
      set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("perf_stall3", perf_stall_cycles_o, 3);
      chk("perf_busy0", perf_busy_cycles_o, 0);
      set(1, 2'b11, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0); nx();
      set(1, 2'b11, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0); nx();
      set(1, 2'b11, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1); nx();
      set(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      chk("perf_busy2", perf_busy_cycles_o, 2);
      chk("perf_stall_hold", perf_stall_cycles_o, 3);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
